// File: rtl/execute_pkg.sv
// execute_pkg: shared types and encodings for the LEGv8 EX stage
package execute_pkg;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MUL  = 2'b01,
        MD_UDIV = 2'b10,
        MD_SDIV = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } md_state_t;

    // operand B select; 10 and 11 both choose readData3_E
    localparam logic [1:0] SRC_REG = 2'b00;
    localparam logic [1:0] SRC_IMM = 2'b01;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

endpackage

// File: rtl/execute_md_iter.sv
// md_iter: iterative 1-bit-per-cycle multiply and restoring divide
module md_iter
    import execute_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  md_op_t       op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int CW = $clog2(N + 1);

    md_state_t     state;
    logic [CW-1:0] cnt;
    // p: accumulator / remainder, q: multiplicand / quotient, d: multiplier / divisor
    logic [N-1:0]  p, q, d;
    logic [N-1:0]  p_nx, q_nx, d_nx, a_mag, b_mag, fin;
    logic [N:0]    sh, trial;
    logic          neg, bz;

    assign busy = reset && !flush &&
                  ((state == IDLE && start) || state == MUL || state == DIV);
    assign done = (state == DONE);

    // one iteration step for either operation, plus the final sign/zero fix-up
    always_comb begin
        a_mag = (op == MD_SDIV && a[N-1]) ? -a : a;
        b_mag = (op == MD_SDIV && b[N-1]) ? -b : b;
        sh    = {p, q[N-1]};
        trial = sh - {1'b0, d};
        p_nx  = (state == MUL) ? p + (d[0] ? q : '0) : (trial[N] ? sh[N-1:0] : trial[N-1:0]);
        q_nx  = (state == MUL) ? q << 1 : {q[N-2:0], ~trial[N]};
        d_nx  = (state == MUL) ? d >> 1 : d;
        fin   = (state == MUL) ? p_nx : bz ? '0 : neg ? -q_nx : q_nx;
    end

    // control FSM and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            p      <= '0;
            q      <= '0;
            d      <= '0;
            result <= '0;
            neg    <= 1'b0;
            bz     <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= (op == MD_MUL) ? MUL : DIV;
                    cnt   <= CW'(N);
                    p     <= '0;
                    q     <= (op == MD_MUL) ? a : a_mag;
                    d     <= (op == MD_MUL) ? b : b_mag;
                    neg   <= (op == MD_SDIV) && (a[N-1] ^ b[N-1]);
                    bz    <= (b == '0);
                end
                MUL, DIV: begin
                    p   <= p_nx;
                    q   <= q_nx;
                    d   <= d_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state  <= DONE;
                        result <= fin;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_md.sv
// execute_md: EX stage with single-cycle ALU/branch path and iterative MUL/DIV
module execute_md
    import execute_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         flush_E,
    input  logic [1:0]   AluSrc,
    input  logic [3:0]   AluControl,
    input  logic [1:0]   MdOp,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] signImm_E,
    input  logic [N-1:0] readData1_E,
    input  logic [N-1:0] readData2_E,
    input  logic [N-1:0] readData3_E,
    output logic [N-1:0] PCBranch_E,
    output logic [N-1:0] aluResult_E,
    output logic [N-1:0] writeData_E,
    output logic         zero_E,
    output logic         stall_E
);

    logic [N-1:0] src_b, alu_y, md_res;
    logic         md_busy, md_done;

    // operand B mux and ALU
    always_comb begin
        src_b = (AluSrc == SRC_REG) ? readData2_E : (AluSrc == SRC_IMM) ? signImm_E : readData3_E;
        case (AluControl)
            ALU_AND:  alu_y = readData1_E & src_b;
            ALU_ORR:  alu_y = readData1_E | src_b;
            ALU_ADD:  alu_y = readData1_E + src_b;
            ALU_SUB:  alu_y = readData1_E - src_b;
            ALU_PASS: alu_y = src_b;
            ALU_NOR:  alu_y = ~(readData1_E | src_b);
            default:  alu_y = '0;
        endcase
    end

    assign PCBranch_E  = PC_E + (signImm_E << 2);
    assign writeData_E = readData2_E;
    assign aluResult_E = md_done ? md_res : alu_y;
    assign zero_E      = (aluResult_E == '0);
    assign stall_E     = md_busy;

    md_iter #(.N(N)) u_md (
        .clk    (clk),
        .reset  (reset),
        .start  (valid_E && MdOp != MD_NONE),
        .op     (md_op_t'(MdOp)),
        .a      (readData1_E),
        .b      (readData2_E),
        .flush  (flush_E),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_res)
    );

endmodule

// File: tb/tb_execute_md.sv
// tb_execute_md: scoreboard bench for the 64- and 32-bit EX stage
module tb_execute_md;
    import execute_pkg::*;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic        z;
        int          stalls;
    } exp_t;

    logic        clk, reset, valid_E, valid32, flush_E;
    logic [1:0]  AluSrc, MdOp;
    logic [3:0]  AluControl;
    logic [63:0] pc, imm, rd1, rd2, rd3, pcb, alu, wd;
    logic        zero, stall_E;
    logic [31:0] pc32, imm32, a32, b32, c32, pcb32, alu32, wd32;
    logic        zero32, stall32;

    exp_t q64[$], q32[$];
    int   errors = 0, checks = 0, sc64 = 0, sc32 = 0;

    execute_md #(.N(64)) dut (
        .clk(clk), .reset(reset), .valid_E(valid_E), .flush_E(flush_E),
        .AluSrc(AluSrc), .AluControl(AluControl), .MdOp(MdOp),
        .PC_E(pc), .signImm_E(imm), .readData1_E(rd1), .readData2_E(rd2), .readData3_E(rd3),
        .PCBranch_E(pcb), .aluResult_E(alu), .writeData_E(wd), .zero_E(zero), .stall_E(stall_E)
    );

    execute_md #(.N(32)) dut32 (
        .clk(clk), .reset(reset), .valid_E(valid32), .flush_E(flush_E),
        .AluSrc(AluSrc), .AluControl(AluControl), .MdOp(MdOp),
        .PC_E(pc32), .signImm_E(imm32), .readData1_E(a32), .readData2_E(b32), .readData3_E(c32),
        .PCBranch_E(pcb32), .aluResult_E(alu32), .writeData_E(wd32), .zero_E(zero32), .stall_E(stall32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: a stall falling edge without flush or reset is a DONE cycle
    always @(negedge clk) begin
        exp_t e;
        if (reset && !flush_E) begin
            if (stall_E) sc64++;
            else if (sc64 > 0) begin
                chk("done64_expected", 64'(q64.size() != 0), 64'd1);
                if (q64.size() != 0) begin
                    e = q64.pop_front();
                    chk({e.name, "_result"}, alu, e.res);
                    chk({e.name, "_zero"}, 64'(zero), 64'(e.z));
                    chk({e.name, "_stall_cycles"}, 64'(sc64), 64'(e.stalls));
                end
                sc64 = 0;
            end
            if (stall32) sc32++;
            else if (sc32 > 0) begin
                chk("done32_expected", 64'(q32.size() != 0), 64'd1);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    chk({e.name, "_result"}, 64'(alu32), e.res);
                    chk({e.name, "_zero"}, 64'(zero32), 64'(e.z));
                    chk({e.name, "_stall_cycles"}, 64'(sc32), 64'(e.stalls));
                end
                sc32 = 0;
            end
        end else begin
            sc64 = 0;
            sc32 = 0;
        end
    end

    task automatic md_run(input bit w32, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] res, input string name);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        e.name   = name;
        e.res    = res;
        e.z      = (res == 64'd0);
        e.stalls = w32 ? 33 : 65;
        MdOp     = op;
        if (w32) begin
            valid_E = 1'b0; valid32 = 1'b1; a32 = a[31:0]; b32 = b[31:0];
            q32.push_back(e);
        end else begin
            valid32 = 1'b0; valid_E = 1'b1; rd1 = a; rd2 = b;
            q64.push_back(e);
        end
        @(negedge clk);
        chk({name, "_accept_stall"}, 64'(w32 ? stall32 : stall_E), 64'd1);
        n = 0;
        while ((w32 ? stall32 : stall_E) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_finished"}, 64'(n < 100), 64'd1);
    endtask

    initial begin
        reset = 1'b0; flush_E = 1'b0; valid_E = 1'b1; valid32 = 1'b0;
        AluSrc = SRC_REG; AluControl = ALU_ADD; MdOp = 2'b00;
        pc = 64'h100; imm = 64'd3; rd1 = 64'd5; rd2 = 64'd7; rd3 = 64'd20;
        pc32 = '0; imm32 = '0; a32 = '0; b32 = '0; c32 = '0;
        #3;
        chk("rst_stall", 64'(stall_E), 64'd0);
        chk("rst_stall32", 64'(stall32), 64'd0);
        chk("rst_add_comb", alu, 64'd12);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("add_result", alu, 64'd12);
        chk("add_stall", 64'(stall_E), 64'd0);
        chk("add_pcbranch", pcb, 64'h10C);
        chk("add_writedata", wd, 64'd7);
        chk("add_zero", 64'(zero), 64'd0);
        AluSrc = SRC_IMM;
        #1 chk("addi_result", alu, 64'd8);
        AluSrc = 2'b10;
        #1 chk("rd3_result", alu, 64'd25);
        AluSrc = SRC_REG; AluControl = ALU_SUB; rd2 = 64'd5;
        #1 chk("sub_result", alu, 64'd0);
        chk("sub_zero", 64'(zero), 64'd1);
        AluControl = ALU_ADD;

        md_run(0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, "mul_neg1x3");
        md_run(0, 2'b11, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "sdiv_m7_2");
        md_run(0, 2'b10, 64'd7, 64'd0, 64'd0, "udiv_by0");
        md_run(0, 2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, "sdiv_ovf");
        md_run(0, 2'b11, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, "sdiv_7_m2");
        md_run(0, 2'b11, -64'sd8, -64'sd2, 64'd4, "sdiv_m8_m2");
        md_run(0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, "udiv_big");
        md_run(0, 2'b01, 64'd6, 64'd7, 64'd42, "b2b_mul");
        md_run(0, 2'b10, 64'd100, 64'd9, 64'd11, "b2b_udiv");

        // flush at iteration 10
        @(posedge clk);
        #1 valid_E = 1'b1; MdOp = 2'b10; rd1 = 64'd100; rd2 = 64'd7;
        repeat (10) @(posedge clk);
        #1 flush_E = 1'b1;
        @(negedge clk);
        chk("flush_stall", 64'(stall_E), 64'd0);
        @(posedge clk);
        #1 flush_E = 1'b0; valid_E = 1'b0;
        @(negedge clk);
        chk("flush_idle_stall", 64'(stall_E), 64'd0);
        chk("flush_comb_result", alu, 64'd107);
        repeat (70) @(negedge clk);

        // reset at iteration 10
        @(posedge clk);
        #1 valid_E = 1'b1; MdOp = 2'b10;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rstmid_stall", 64'(stall_E), 64'd0);
        chk("rstmid_comb_result", alu, 64'd107);
        @(posedge clk);
        #1 reset = 1'b1; valid_E = 1'b0;
        @(negedge clk);
        chk("rstmid_idle_stall", 64'(stall_E), 64'd0);
        repeat (70) @(negedge clk);
        md_run(0, 2'b10, 64'd1000, 64'd3, 64'd333, "udiv_after_rst");

        md_run(1, 2'b01, 64'h1_0000, 64'h1_0000, 64'd0, "mul32_wrap");
        md_run(1, 2'b11, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, "sdiv32_m7_2");
        md_run(1, 2'b10, 64'd1000, 64'd3, 64'd333, "udiv32");

        @(posedge clk);
        #1 valid32 = 1'b0; valid_E = 1'b0;
        repeat (3) @(negedge clk);
        chk("q64_drained", 64'(q64.size()), 64'd0);
        chk("q32_drained", 64'(q32.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
- Next-generation EX stage for the pipelined LEGv8 core, parametrised in datapath width N.
- Keeps the single-cycle ALU/branch-target path: operand mux (Rm / signImm / Rd-for-exceptions), ALU, sl2 + adder.
- Adds an iterative multiply/divide unit for MUL, UDIV and SDIV.
- Requests a pipeline stall while an iterative operation is in flight; sits between the ID/EX and EX/MEM registers.

Parameters:
- N, 64, datapath width in bits; legal values are 64 and 32.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- valid_E  in  1  ID/EX holds a real instruction
- flush_E  in  1  squash the current EX instruction (branch/exception)
- AluSrc  in  2  operand B select: 00 readData2_E, 01 signImm_E, 10/11 readData3_E
- AluControl  in  4  ALU function, existing encoding
- MdOp  in  2  00 none, 01 MUL, 10 UDIV, 11 SDIV
- PC_E  in  N  instruction PC
- signImm_E  in  N  sign-extended immediate
- readData1_E, readData2_E, readData3_E  in  N each  register operands
- PCBranch_E  out  N  PC_E + (signImm_E << 2), always combinational
- aluResult_E  out  N  ALU result, or MD result in DONE
- writeData_E  out  N  readData2_E, passthrough
- zero_E  out  1  aluResult_E == 0
- stall_E  out  1  hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM

Behaviour:
- MdOp==00 or valid_E==0: the block is purely combinational, as in the previous EX stage. stall_E=0.
- FSM states: IDLE, MUL, DIV, DONE. Reset value: IDLE, counter 0, all datapath registers 0.
- IDLE, with valid_E=1, MdOp!=00 and flush_E=0:
  - stall_E=1 in the same cycle (combinational).
  - Capture the operands: A=readData1_E, B=readData2_E (AluSrc is ignored for MD ops).
  - Next state: MUL for MdOp 01, DIV otherwise. Counter loads N.
- MUL: shift-add, 1 bit per cycle, exactly N cycles. Result is the low N bits of A*B (signedness is irrelevant for the low half). stall_E=1.
- DIV: restoring division on the magnitudes, 1 bit per cycle, exactly N cycles. stall_E=1.
  - SDIV: quotient sign = sign(A) XOR sign(B); the result truncates toward zero.
  - B==0: quotient is 0 for UDIV and SDIV. No exception.
  - SDIV with A=most-negative and B=-1: result is the most-negative value (wraps).
- Leaving MUL/DIV: when the counter reaches 1, the next state is DONE.
- DONE (exactly one cycle):
  - stall_E=0. aluResult_E = MD result register; zero_E is derived from it.
  - The pipeline advances. Next state is IDLE; the instruction now in ID/EX is a new one.
- Latency: an MD instruction stays in EX for N+2 cycles (accept + N iterations + DONE). stall_E is high for N+1 of them.
- flush_E=1 in any state: next state IDLE, stall_E=0 in that cycle, result discarded.
- reset asserted mid-operation: immediately IDLE, outputs revert to the combinational path, stall_E=0.
- Back-to-back MD instructions: DONE → IDLE, then the next MD op is accepted in that IDLE cycle. There is no lost cycle beyond DONE.
- Inputs are held stable by the stall; the block does not re-sample them after accept.

Decomposition:
- Package execute_pkg:
  - md_op_t enum (MD_NONE, MD_MUL, MD_UDIV, MD_SDIV)
  - md_state_t enum (IDLE, MUL, DIV, DONE)
  - AluSrc encoding constants
- Sub-module md_iter (parameter N): FSM, counter, accumulator/remainder, sign fix-up.
  - Inputs: start, op, a, b, flush.
  - Outputs: busy, done, result.
- Top level: existing mux4, alu, sl2, adder; an output mux selecting md_iter.result when done.

Test Plan:
- R-type ADD, MdOp=00: readData1_E=5, readData2_E=7 → aluResult_E=12 in the same cycle; stall_E=0. PC_E=0x100, signImm_E=3 → PCBranch_E=0x10C.
- MUL, A=0xFFFF_FFFF_FFFF_FFFF, B=3, N=64 → stall_E high 65 cycles; DONE cycle aluResult_E=0xFFFF_FFFF_FFFF_FFFD, zero_E=0.
- SDIV, A=-7, B=2 → result -3. UDIV, A=7, B=0 → result 0 with zero_E=1. SDIV, A=0x8000_0000_0000_0000, B=-1 → 0x8000_0000_0000_0000.
- UDIV started, flush_E at iteration 10 → stall_E=0 in that cycle, state IDLE next, no DONE pulse. Repeat with reset low at iteration 10 → same, with registers cleared.
- Back-to-back MUL 6*7 then UDIV 100/9 → results 42 then 11. The second accept occurs in the cycle after the first DONE.
- N=32 instance: MUL 0x10000*0x10000 → 0 with zero_E=1; stall lasts 33 cycles.
